htif_responder: RTL

HTIF_RESPONDER -- requirements
Module: htif_responder

---
 rtl/htif_responder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/htif_responder.sv
// Host-target interface responder: holds tohost/fromhost, decodes tohost commands
// into program exit or console putchar, and acknowledges putchar through fromhost.
module htif_responder (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [3:0]  req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        cons_valid,
   input  logic        cons_ready,
   output logic [7:0]  cons_data,
   output logic        exit_valid,
   output logic [46:0] exit_code,
   output logic        halted,
   output logic        bad_cmd
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_CONS,
      S_ACK,
      S_HALT
   } state_t;

   localparam logic [3:0]  ADDR_TOHOST   = 4'h0;
   localparam logic [3:0]  ADDR_FROMHOST = 4'h8;
   localparam logic [63:0] PUTCHAR_ACK   = {8'h01, 8'h01, 48'h0};

   state_t      r_state;
   state_t      w_state_nxt;
   logic [63:0] r_tohost;
   logic [63:0] r_fromhost;
   logic        r_resp_valid;
   logic [63:0] r_resp_rdata;
   logic        r_cons_valid;
   logic [7:0]  r_cons_data;
   logic        r_exit_valid;
   logic [46:0] r_exit_code;
   logic        r_halted;
   logic        r_bad_cmd;

   logic [63:0] w_tohost_nxt;
   logic [63:0] w_fromhost_nxt;
   logic        w_cons_valid_nxt;
   logic [7:0]  w_cons_data_nxt;
   logic        w_exit_valid_nxt;
   logic [46:0] w_exit_code_nxt;
   logic        w_halted_nxt;
   logic        w_bad_cmd_nxt;
   logic [63:0] w_resp_rdata_nxt;

   logic        w_ready;
   logic        w_accept;
   logic        w_wr_tohost;
   logic        w_wr_fromhost;
   logic [7:0]  w_dev;
   logic [7:0]  w_cmd;
   logic [47:0] w_payload;

   assign w_dev     = r_tohost[63:56];
   assign w_cmd     = r_tohost[55:48];
   assign w_payload = r_tohost[47:0];

   // ACK only lets the core in to clear fromhost; everything else waits.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_IDLE, S_HALT: w_ready = 1'b1;
         S_ACK:          w_ready = (req_addr == ADDR_FROMHOST) && req_write;
         default:        w_ready = 1'b0;
      endcase
   end

   assign req_ready     = reset && w_ready;
   assign w_accept      = req_valid && req_ready;
   assign w_wr_tohost   = w_accept && req_write && (req_addr == ADDR_TOHOST);
   assign w_wr_fromhost = w_accept && req_write && (req_addr == ADDR_FROMHOST);

   always_comb begin
      w_resp_rdata_nxt = 64'h0;
      if (w_accept && !req_write) begin
         case (req_addr)
            ADDR_TOHOST:   w_resp_rdata_nxt = r_tohost;
            ADDR_FROMHOST: w_resp_rdata_nxt = r_fromhost;
            default:       w_resp_rdata_nxt = 64'h0;
         endcase
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_tohost_nxt     = r_tohost;
      w_fromhost_nxt   = r_fromhost;
      w_cons_valid_nxt = r_cons_valid;
      w_cons_data_nxt  = r_cons_data;
      w_exit_valid_nxt = 1'b0;
      w_exit_code_nxt  = r_exit_code;
      w_halted_nxt     = r_halted;
      w_bad_cmd_nxt    = 1'b0;

      if (w_wr_fromhost) begin
         w_fromhost_nxt = req_wdata;
      end

      case (r_state)
         S_IDLE: begin
            if (w_wr_tohost) begin
               w_tohost_nxt = req_wdata;
               if (req_wdata != 64'h0) begin
                  w_state_nxt = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            if ((w_dev == 8'h00) && (w_cmd == 8'h00) && w_payload[0]) begin
               w_exit_valid_nxt = 1'b1;
               w_exit_code_nxt  = w_payload[47:1];
               w_halted_nxt     = 1'b1;
               w_tohost_nxt     = 64'h0;
               w_state_nxt      = S_HALT;
            end else if ((w_dev == 8'h01) && (w_cmd == 8'h01)) begin
               w_cons_valid_nxt = 1'b1;
               w_cons_data_nxt  = w_payload[7:0];
               w_state_nxt      = S_CONS;
            end else begin
               w_bad_cmd_nxt = 1'b1;
               w_tohost_nxt  = 64'h0;
               w_state_nxt   = S_IDLE;
            end
         end
         S_CONS: begin
            if (cons_ready) begin
               w_cons_valid_nxt = 1'b0;
               w_tohost_nxt     = 64'h0;
               w_state_nxt      = S_ACK;
            end
         end
         S_ACK: begin
            // A core write this cycle owns fromhost; the ack retries next cycle.
            if (!w_wr_fromhost && (r_fromhost == 64'h0)) begin
               w_fromhost_nxt = PUTCHAR_ACK;
               w_state_nxt    = S_IDLE;
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_tohost     <= 64'h0;
         r_fromhost   <= 64'h0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 64'h0;
         r_cons_valid <= 1'b0;
         r_cons_data  <= 8'h0;
         r_exit_valid <= 1'b0;
         r_exit_code  <= 47'h0;
         r_halted     <= 1'b0;
         r_bad_cmd    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_tohost     <= w_tohost_nxt;
         r_fromhost   <= w_fromhost_nxt;
         r_resp_valid <= w_accept;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_cons_valid <= w_cons_valid_nxt;
         r_cons_data  <= w_cons_data_nxt;
         r_exit_valid <= w_exit_valid_nxt;
         r_exit_code  <= w_exit_code_nxt;
         r_halted     <= w_halted_nxt;
         r_bad_cmd    <= w_bad_cmd_nxt;
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign cons_valid = r_cons_valid;
   assign cons_data  = r_cons_data;
   assign exit_valid = r_exit_valid;
   assign exit_code  = r_exit_code;
   assign halted     = r_halted;
   assign bad_cmd    = r_bad_cmd;

endmodule
